// File: rtl/addsub_pkg.sv
// Shared definitions for the digit-serial adder/subtractor: FSM encoding and
// a constant-function log2 used to size the step counter.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/digit_serial_addsub_if.sv
// Operand/result handshake bundle between a producer/consumer (master) and
// the digit-serial adder/subtractor (slave).
interface digit_serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, carry_out, overflow, zero
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, carry_out, overflow, zero
  );
endinterface

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple adder; also exposes the carry into its top
// bit so the caller can derive signed overflow on the final digit.
module digit_adder #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             cmsb
);
  logic [DIGIT:0] c;

  assign c[0] = cin;

  generate
    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_fa
      fullAdder u_fa (
        .a   (a[gi]),
        .b   (b[gi]),
        .cin (c[gi]),
        .s   (s[gi]),
        .cout(c[gi+1])
      );
    end
  endgenerate

  assign cout = c[DIGIT];
  assign cmsb = c[DIGIT-1];
endmodule

// File: rtl/fullAdder.sv
// One-bit full adder cell, the building block of the digit ripple.
module fullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/digit_serial_addsub.sv
// Multi-cycle two's-complement adder/subtractor: consumes DIGIT bits per clock,
// LSB digit first, with the carry held in a register between cycles.
module digit_serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  digit_serial_addsub_if.slave bus
);
  generate
    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
      $error("digit_serial_addsub: DIGIT must be >=1 and divide WIDTH");
    end
  endgenerate

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = (clog2(STEPS) < 1) ? 1 : clog2(STEPS);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             co_q, co_d, ov_q, ov_d, zero_q, zero_d;

  logic [DIGIT-1:0] dig_s;
  logic             dig_cout, dig_cmsb;
  logic [WIDTH-1:0] sum_shift;
  logic             last_step;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a   (a_q[DIGIT-1:0]),
    .b   (b_q[DIGIT-1:0]),
    .cin (carry_q),
    .s   (dig_s),
    .cout(dig_cout),
    .cmsb(dig_cmsb)
  );

  // New digit enters at the top so the word is aligned after STEPS shifts.
  generate
    if (STEPS == 1) begin : g_one_step
      assign sum_shift = dig_s;
    end else begin : g_multi_step
      assign sum_shift = {dig_s, sum_q[WIDTH-1:DIGIT]};
    end
  endgenerate

  assign last_step = (cnt_q == CW'(STEPS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = RUN;
      RUN:     if (last_step) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
  end

  // Subtraction is a + ~b + 1: the +1 rides in as the initial carry.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    co_d    = co_q;
    ov_d    = ov_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub;
          cnt_d   = '0;
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        sum_d   = sum_shift;
        carry_d = dig_cout;
        cnt_d   = cnt_q + CW'(1);
        if (last_step) begin
          co_d   = dig_cout;
          ov_d   = dig_cout ^ dig_cmsb;
          zero_d = (sum_shift == '0);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      co_q    <= co_d;
      ov_q    <= ov_d;
      zero_q  <= zero_d;
    end
  end

  assign bus.sum       = sum_q;
  assign bus.carry_out = co_q;
  assign bus.overflow  = ov_q;
  assign bus.zero      = zero_q;
endmodule
